// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the IF/ID boundary: exception codes,
// architectural PCs, and the opcode/funct values that identify branches
// and jumps. Also imported by the decoder and CP0.
package if_id_stage_pkg;

  // Exception codes carried down the pipe
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  // Architectural PCs
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  // Primary opcodes that transfer control
  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  OP_REGIMM  = 6'b000001;
  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_JAL     = 6'b000011;
  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam logic [5:0]  OP_BNE     = 6'b000101;
  localparam logic [5:0]  OP_BLEZ    = 6'b000110;
  localparam logic [5:0]  OP_BGTZ    = 6'b000111;

  // SPECIAL funct codes that transfer control
  localparam logic [5:0]  FN_JR      = 6'b001000;
  localparam logic [5:0]  FN_JALR    = 6'b001001;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
    logic        bd;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_jb_predecode.sv
// Combinational branch/jump predecode. Flags any instruction whose
// successor occupies a branch delay slot.
module jb_predecode
  import if_id_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_jb_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  // Classify by opcode, and by funct for the SPECIAL register jumps
  always_comb begin
    is_jb_o = 1'b0;
    case (opcode)
      OP_REGIMM, OP_J, OP_JAL,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_jb_o = 1'b1;
      OP_SPECIAL: is_jb_o = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_jb_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. Captures the fetched PC/instruction, turns a
// fetch address error into a zeroed instruction with ExcCode AdEL, tracks
// the branch-delay-slot flag, and collapses to a handler bubble when CP0
// takes an exception or interrupt.
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        stall,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic        F_exc_adel,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic        D_valid,
  output logic        D_jb
);

  if_id_t slot_q;
  if_id_t slot_d;
  logic   held_is_jb;

  // Predecode of the instruction currently sitting in decode
  jb_predecode u_jb_predecode (
    .instr_i (slot_q.instr),
    .is_jb_o (held_is_jb)
  );

  // A bubble never counts as a branch, whatever its instruction field holds
  assign D_jb = slot_q.valid & held_is_jb;

  // Next slot contents: flush beats stall, stall beats advance
  always_comb begin
    slot_d = slot_q;
    if (req) begin
      slot_d.pc      = HANDLER_PC;
      slot_d.instr   = '0;
      slot_d.exccode = EXC_NONE;
      slot_d.bd      = 1'b0;
      slot_d.valid   = 1'b0;
    end else if (!stall) begin
      slot_d.pc      = F_pc;
      slot_d.valid   = 1'b1;
      // The incoming instruction is a delay slot iff the one leaving was a branch
      slot_d.bd      = D_jb;
      if (F_exc_adel) begin
        slot_d.instr   = '0;
        slot_d.exccode = EXC_ADEL;
      end else begin
        slot_d.instr   = F_instr;
        slot_d.exccode = EXC_NONE;
      end
    end
  end

  // Register update with synchronous reset taking precedence over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q.pc      <= RESET_PC;
      slot_q.instr   <= '0;
      slot_q.exccode <= EXC_NONE;
      slot_q.bd      <= 1'b0;
      slot_q.valid   <= 1'b0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign D_pc      = slot_q.pc;
  assign D_instr   = slot_q.instr;
  assign D_exccode = slot_q.exccode;
  assign D_bd      = slot_q.bd;
  assign D_valid   = slot_q.valid;

endmodule
